// File: rtl/debounce_multi_if.sv
// rtl/debounce_multi_if.sv - channel bundle between switch inputs and debounced outputs
interface debounce_multi_if #(
  parameter int CHANNELS = 4,
  parameter int CNT_W    = 20
);
  logic [CHANNELS-1:0] noisy_in;
  logic [CNT_W-1:0]    threshold;
  logic [CHANNELS-1:0] clean_out;
  logic [CHANNELS-1:0] rise_pulse;
  logic [CHANNELS-1:0] fall_pulse;
  logic                any_change;

  modport master (
    output noisy_in, threshold,
    input  clean_out, rise_pulse, fall_pulse, any_change
  );

  modport slave (
    input  noisy_in, threshold,
    output clean_out, rise_pulse, fall_pulse, any_change
  );
endinterface

// File: rtl/debounce_multi.sv
// rtl/debounce_multi.sv - multi-channel debouncer; edge pulses built when DEBOUNCE_MULTI_EDGE_EN is defined
module debounce_multi #(
  parameter int   CHANNELS    = 4,
  parameter int   CNT_W       = 20,
  parameter int   SYNC_STAGES = 2,
  parameter logic RESET_VAL   = 1'b0
) (
  input logic              clk,
  input logic              rst_n,
  debounce_multi_if.slave  bus
);

  logic [SYNC_STAGES-1:0] sync_chain [CHANNELS];
  logic [CNT_W-1:0]       cnt        [CHANNELS];
  logic [CHANNELS-1:0]    sync_last;
  logic [CHANNELS-1:0]    mismatch;
  logic [CHANNELS-1:0]    commit;
  logic [CHANNELS-1:0]    clean_q;
  logic                   any_q;

  // Tap the last synchroniser stage and decide which channels commit this cycle.
  // Commit happens before the counter could pass threshold, so it never wraps.
  always_comb begin
    sync_last = '0;
    mismatch  = '0;
    commit    = '0;
    for (int i = 0; i < CHANNELS; i++) begin
      sync_last[i] = sync_chain[i][SYNC_STAGES-1];
      mismatch[i]  = sync_last[i] != clean_q[i];
      commit[i]    = mismatch[i] && (cnt[i] >= bus.threshold);
    end
  end

  // Per-channel synchroniser shift chains for the asynchronous inputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < CHANNELS; i++)
        sync_chain[i] <= {SYNC_STAGES{RESET_VAL}};
    end else begin
      for (int i = 0; i < CHANNELS; i++)
        sync_chain[i] <= {sync_chain[i][SYNC_STAGES-2:0], bus.noisy_in[i]};
    end
  end

  // Stability counters: any matching sample or a commit restarts the run.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < CHANNELS; i++)
        cnt[i] <= '0;
    end else begin
      for (int i = 0; i < CHANNELS; i++) begin
        if (!mismatch[i] || commit[i])
          cnt[i] <= '0;
        else
          cnt[i] <= cnt[i] + CNT_W'(1);
      end
    end
  end

  // Debounced levels and the shared change strobe.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      clean_q <= {CHANNELS{RESET_VAL}};
      any_q   <= 1'b0;
    end else begin
      for (int i = 0; i < CHANNELS; i++)
        if (commit[i])
          clean_q[i] <= sync_last[i];
      any_q <= |commit;
    end
  end

  assign bus.clean_out  = clean_q;
  assign bus.any_change = any_q;

`ifdef DEBOUNCE_MULTI_EDGE_EN
  logic [CHANNELS-1:0] rise_q;
  logic [CHANNELS-1:0] fall_q;

  // One-cycle edge pulses aligned with the clean_out update.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rise_q <= '0;
      fall_q <= '0;
    end else begin
      rise_q <= commit & sync_last;
      fall_q <= commit & ~sync_last;
    end
  end

  assign bus.rise_pulse = rise_q;
  assign bus.fall_pulse = fall_q;
`else
  assign bus.rise_pulse = '0;
  assign bus.fall_pulse = '0;
`endif

endmodule

// File: tb/tb_debounce_multi.sv
// tb/tb_debounce_multi.sv - directed and random checks of debounce_multi against a run-length reference model
module tb_debounce_multi;

  localparam int   CH  = 4;
  localparam int   CW  = 8;
  localparam int   SS  = 2;
  localparam logic RV  = 1'b0;
  localparam int   THR = 5;
`ifdef DEBOUNCE_MULTI_EDGE_EN
  localparam bit EDGE = 1'b1;
`else
  localparam bit EDGE = 1'b0;
`endif

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  debounce_multi_if #(.CHANNELS(CH), .CNT_W(CW)) bus ();

  debounce_multi #(
    .CHANNELS(CH), .CNT_W(CW), .SYNC_STAGES(SS), .RESET_VAL(RV)
  ) dut (
    .clk(clk), .rst_n(rst_n), .bus(bus)
  );

  // Reference model: inputs travel through a sample queue of depth SS; each
  // channel remembers the synchronised samples seen since its last commit and
  // commits when the trailing run of differing samples reaches threshold.
  logic [CH-1:0] pipe_q [$];
  bit            seen [CH][$];
  logic [CH-1:0] m_clean, m_rise, m_fall;
  logic          m_any;
  int            n_checks = 0;
  int            n_fails  = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fails++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    pipe_q.delete();
    for (int k = 0; k < SS; k++) pipe_q.push_back({CH{RV}});
    for (int c = 0; c < CH; c++) seen[c].delete();
    m_clean = {CH{RV}};
    m_rise  = '0;
    m_fall  = '0;
    m_any   = 1'b0;
  endtask

  task automatic model_edge();
    logic [CH-1:0] s;
    logic [CH-1:0] commit;
    int run;
    s      = pipe_q[0];
    commit = '0;
    for (int c = 0; c < CH; c++) begin
      if (s[c] != m_clean[c]) begin
        run = 0;
        for (int k = seen[c].size() - 1; k >= 0 && seen[c][k] != m_clean[c]; k--) run++;
        if (run >= int'(bus.threshold)) commit[c] = 1'b1;
      end
    end
    for (int c = 0; c < CH; c++) begin
      if (commit[c]) begin
        m_clean[c] = s[c];
        seen[c].delete();
      end else begin
        seen[c].push_back(s[c]);
      end
    end
    m_rise = EDGE ? (commit & s)  : '0;
    m_fall = EDGE ? (commit & ~s) : '0;
    m_any  = |commit;
    void'(pipe_q.pop_front());
    pipe_q.push_back(bus.noisy_in);
  endtask

  task automatic check_outputs(input string tag);
    check({tag, ".clean"}, 32'(bus.clean_out),  32'(m_clean));
    check({tag, ".rise"},  32'(bus.rise_pulse), 32'(m_rise));
    check({tag, ".fall"},  32'(bus.fall_pulse), 32'(m_fall));
    check({tag, ".any"},   32'(bus.any_change), 32'(m_any));
  endtask

  // Advance one clock: model consumes the pre-edge inputs, DUT sampled at +1.
  task automatic tick();
    if (rst_n) model_edge();
    else       model_reset();
    @(posedge clk);
    #1;
    check_outputs("cycle");
  endtask

  task automatic wait_change(input int ch, input int budget, output int edges);
    logic start;
    start = bus.clean_out[ch];
    edges = 0;
    while (bus.clean_out[ch] === start && edges < budget) begin
      tick();
      edges++;
    end
  endtask

  int e;

  initial begin
    rst_n         = 1'b0;
    bus.noisy_in  = 4'hF;
    bus.threshold = CW'(THR);
    #1;
    model_reset();
    check_outputs("reset");
    repeat (3) tick();

    // Release with inputs high: no pulses before the first commit.
    rst_n = 1'b1;
    for (int k = 0; k < 3; k++) begin
      tick();
      check("release_quiet", 32'(bus.rise_pulse | bus.fall_pulse | {CH{bus.any_change}}), 32'd0);
    end
    bus.noisy_in = 4'h0;
    repeat (10) tick();

    // Clean step on channel 0.
    bus.noisy_in[0] = 1'b1;
    wait_change(0, 20, e);
    check("step_latency", 32'(e), 32'(SS + THR + 1));
    check("step_rise", 32'(bus.rise_pulse), EDGE ? 32'h1 : 32'h0);
    check("step_any", 32'(bus.any_change), 32'h1);
    check("step_others", 32'(bus.clean_out[3:1]), 32'h0);
    tick();
    check("step_pulse_end", 32'(bus.rise_pulse | {CH{bus.any_change}}), 32'h0);

    // Glitch of threshold cycles is rejected, threshold+1 cycles propagates.
    bus.noisy_in[1] = 1'b1;
    repeat (5) tick();
    bus.noisy_in[1] = 1'b0;
    repeat (12) tick();
    check("glitch_reject", 32'(bus.clean_out[1]), 32'h0);
    bus.noisy_in[1] = 1'b1;
    repeat (6) tick();
    bus.noisy_in[1] = 1'b0;
    wait_change(1, 10, e);
    check("glitch_accept_latency", 32'(e + 6), 32'd8);
    wait_change(1, 20, e);
    check("glitch_fallback", 32'(bus.clean_out[1]), 32'h0);

    // Simultaneous rise and fall on channels 3:2.
    bus.noisy_in[3:2] = 2'b11;
    wait_change(2, 20, e);
    check("simul_clean", 32'(bus.clean_out[3:2]), 32'h3);
    check("simul_rise", 32'(bus.rise_pulse), EDGE ? 32'hC : 32'h0);
    check("simul_any", 32'(bus.any_change), 32'h1);
    bus.noisy_in[3:2] = 2'b00;
    wait_change(2, 20, e);
    check("simul_fall", 32'(bus.fall_pulse), EDGE ? 32'hC : 32'h0);

    // Lower threshold below an in-flight count of 4 on channel 0.
    bus.noisy_in[0] = 1'b0;
    repeat (6) tick();
    bus.threshold = CW'(2);
    tick();
    check("thr_drop_commit", 32'(bus.clean_out[0]), 32'h0);

    // Threshold 0: a single synchronised sample commits.
    bus.threshold   = '0;
    bus.noisy_in[0] = 1'b1;
    tick();
    bus.noisy_in[0] = 1'b0;
    tick();
    tick();
    check("thr0_rise", 32'(bus.clean_out[0]), 32'h1);
    tick();
    check("thr0_fall", 32'(bus.clean_out[0]), 32'h0);
    bus.threshold = CW'(THR);
    repeat (4) tick();

    // Asynchronous reset in the middle of a count on channel 2.
    bus.noisy_in[2] = 1'b1;
    wait_change(2, 20, e);
    check("pre_reset_clean", 32'(bus.clean_out[2]), 32'h1);
    bus.noisy_in[2] = 1'b0;
    repeat (5) tick();
    rst_n = 1'b0;
    #1;
    model_reset();
    check_outputs("async_reset");
    bus.noisy_in[2] = 1'b1;
    repeat (2) tick();
    rst_n = 1'b1;
    wait_change(2, 20, e);
    check("post_reset_latency", 32'(e), 32'(SS + THR + 1));

    // Random toggling, threshold changes and occasional resets.
    for (int n = 0; n < 500; n++) begin
      for (int c = 0; c < CH; c++)
        if ($urandom_range(0, 5) == 0) bus.noisy_in[c] = ~bus.noisy_in[c];
      if (n % 60 == 0) bus.threshold = CW'($urandom_range(0, 6));
      if ($urandom_range(0, 149) == 0) rst_n = 1'b0;
      else                             rst_n = 1'b1;
      tick();
    end
    rst_n = 1'b1;

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
    $finish;
  end

endmodule
